// File: rtl/grn_node_pkg.sv
`default_nettype none
// ============================================================================
// Module      : grn_node_pkg
// Description : Shared defaults and field-extraction helper for grn_node_mc.
// Revision    : 1.0 - initial release
// ============================================================================
package grn_node_pkg;

    localparam int NCH_DEF   = 2;
    localparam int W_DEF     = 1;
    localparam int DIVW_DEF  = 3;
    localparam int STBW_DEF  = 8;
    localparam int STB_MAX   = (1 << STBW_DEF) - 1;

    // Widest packed vector / field the helper handles
    localparam int VEC_MAXW   = 256;
    localparam int FIELD_MAXW = 64;

    function automatic logic [FIELD_MAXW-1:0] field(
        input logic [VEC_MAXW-1:0] vec,
        input int unsigned         c,
        input int unsigned         width
    );
        logic [VEC_MAXW-1:0]   shifted;
        logic [FIELD_MAXW-1:0] mask;
        shifted = vec >> (c * width);
        mask    = (width >= FIELD_MAXW) ? '1 : ((FIELD_MAXW'(1) << width) - FIELD_MAXW'(1));
        return shifted[FIELD_MAXW-1:0] & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/grn_node_ch.sv
`default_nettype none
// ============================================================================
// Module      : grn_node_ch
// Description : One GRN node state copy: divided commit, stability counter,
//               optional history (GRN_NODE_HISTORY_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module grn_node_ch
    import grn_node_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int DIVW = DIVW_DEF,
    parameter int STBW = STBW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            reset_nos,
    input  logic [W-1:0]    init_state,
    input  logic            start,
    input  logic [DIVW-1:0] div,
    input  logic [W-1:0]    next_state,
    input  logic [STBW-1:0] stable_thr,
    output logic [W-1:0]    s,
    output logic            upd,
`ifdef GRN_NODE_HISTORY_EN
    output logic [W-1:0]    s_prev,
    output logic            changed,
`endif
    output logic            stable
);

    logic [DIVW-1:0] cnt;
    logic [STBW-1:0] stbcnt;
    logic            commit;

    assign commit = start && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            s      <= '0;
            cnt    <= '0;
            stbcnt <= '0;
            upd    <= 1'b0;
        end else if (reset_nos) begin
            s      <= init_state;
            cnt    <= '0;
            stbcnt <= '0;
            upd    <= 1'b0;
        end else if (commit) begin
            s   <= next_state;
            cnt <= div;
            upd <= 1'b1;
            // Saturate rather than wrap so a long-stable copy never looks unstable
            if (next_state == s) begin
                if (stbcnt != '1)
                    stbcnt <= stbcnt + 1'b1;
            end else begin
                stbcnt <= '0;
            end
        end else begin
            if (start)
                cnt <= cnt - 1'b1;
            upd <= 1'b0;
        end
    end

    assign stable = (stable_thr != '0) && (stbcnt >= stable_thr);

`ifdef GRN_NODE_HISTORY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            s_prev  <= '0;
            changed <= 1'b0;
        end else if (reset_nos) begin
            s_prev  <= init_state;
            changed <= 1'b0;
        end else if (commit) begin
            s_prev  <= s;
            changed <= (next_state != s);
        end else begin
            changed <= 1'b0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/grn_node_mc.sv
`default_nettype none
// ============================================================================
// Module      : grn_node_mc
// Description : Multi-copy GRN node; NCH independent copies of grn_node_ch.
//               Optional history outputs under GRN_NODE_HISTORY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module grn_node_mc
    import grn_node_pkg::*;
#(
    parameter int NCH  = NCH_DEF,
    parameter int W    = W_DEF,
    parameter int DIVW = DIVW_DEF,
    parameter int STBW = STBW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                reset_nos,
    input  logic [W-1:0]        init_state,
    input  logic [NCH-1:0]      start,
    input  logic [NCH*DIVW-1:0] div,
    input  logic [NCH*W-1:0]    next_state,
    input  logic [STBW-1:0]     stable_thr,
    output logic [NCH*W-1:0]    s,
    output logic [NCH-1:0]      upd,
`ifdef GRN_NODE_HISTORY_EN
    output logic [NCH*W-1:0]    s_prev,
    output logic [NCH-1:0]      changed,
`endif
    output logic [NCH-1:0]      stable
);

    logic [VEC_MAXW-1:0] div_ext;
    logic [VEC_MAXW-1:0] ns_ext;

    assign div_ext = VEC_MAXW'(div);
    assign ns_ext  = VEC_MAXW'(next_state);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [DIVW-1:0] div_c;
        logic [W-1:0]    ns_c;
        logic [W-1:0]    s_c;

        assign div_c = DIVW'(field(div_ext, c, DIVW));
        assign ns_c  = W'(field(ns_ext, c, W));
        assign s[c*W +: W] = s_c;

`ifdef GRN_NODE_HISTORY_EN
        logic [W-1:0] s_prev_c;
        assign s_prev[c*W +: W] = s_prev_c;
`endif

        grn_node_ch #(
            .W    (W),
            .DIVW (DIVW),
            .STBW (STBW)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .reset_nos  (reset_nos),
            .init_state (init_state),
            .start      (start[c]),
            .div        (div_c),
            .next_state (ns_c),
            .stable_thr (stable_thr),
            .s          (s_c),
            .upd        (upd[c]),
`ifdef GRN_NODE_HISTORY_EN
            .s_prev     (s_prev_c),
            .changed    (changed[c]),
`endif
            .stable     (stable[c])
        );
    end

endmodule
`default_nettype wire
